// File: rtl/mux_8x1.sv
// 8-to-1 lane multiplexer with a combinational output and a registered
// (output, select) pair that is captured together so the two stay coherent.
module mux_8x1 #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [8*WIDTH-1:0]   data,
    input  logic [2:0]           sel,
    output logic [WIDTH-1:0]     y,
    output logic [WIDTH-1:0]     y_q,
    output logic [2:0]           sel_q
);

    logic [WIDTH-1:0] lanes [8];

    for (genvar k = 0; k < 8; k++) begin : g_lane
        assign lanes[k] = data[k*WIDTH +: WIDTH];
    end

    // Indexing the lane array directly means an unknown select yields an
    // unknown output instead of silently falling back to some lane.
    assign y = lanes[sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= '0;
            sel_q <= '0;
        end else if (en) begin
            y_q   <= y;
            sel_q <= sel;
        end
    end

endmodule

// File: tb/tb_mux_8x1.sv
// Self-checking bench for mux_8x1: expectations are queued when stimulus is
// driven and popped in order as the corresponding DUT outputs are sampled.
module tb_mux_8x1;

    localparam int W = 1;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [8*W-1:0]   data;
    logic [2:0]       sel;
    logic [W-1:0]     y;
    logic [W-1:0]     y_q;
    logic [2:0]       sel_q;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    logic [7:0] capY = 8'h0;
    logic [7:0] capSel = 8'h0;

    mux_8x1 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .data  (data),
        .sel   (sel),
        .y     (y),
        .y_q   (y_q),
        .sel_q (sel_q)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] s);
        return {7'b0, d[s]};
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic popCheck(input logic [7:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            checkOutput("sb_underflow", 8'(sb.size()), 8'd1);
        end else begin
            e = sb.pop_front();
            checkOutput(e.tag, obs, e.val);
        end
    endtask

    task automatic applyComb(input string tag, input logic [7:0] d, input logic [2:0] s);
        data = d;
        sel  = s;
        sb.push_back('{tag, model(d, s)});
    endtask

    // Drives a full transaction and queues y, then y_q/sel_q for the next edge.
    task automatic applyStimulus(input string tag, input logic [7:0] d, input logic [2:0] s,
                                 input logic e);
        applyComb({tag, "_y"}, d, s);
        en = e;
        if (e) begin
            capY   = model(d, s);
            capSel = {5'b0, s};
        end
        sb.push_back('{{tag, "_yq"}, capY});
        sb.push_back('{{tag, "_selq"}, capSel});
    endtask

    task automatic checkRegs();
        popCheck({7'b0, y_q});
        popCheck({5'b0, sel_q});
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        data  = 8'h00;
        sel   = 3'd0;
        #2;
        sb.push_back('{"reset_yq", 8'h0});
        sb.push_back('{"reset_selq", 8'h0});
        checkRegs();

        for (int s = 0; s < 8; s++) begin
            applyComb($sformatf("sweep55_s%0d", s), 8'h55, 3'(s));
            #1 popCheck({7'b0, y});
            #9;
        end
        for (int s = 0; s < 8; s++) begin
            applyComb($sformatf("sweepAA_s%0d", s), 8'hAA, 3'(s));
            #1 popCheck({7'b0, y});
            #9;
        end

        applyComb("track_hi", 8'hAA, 3'd3);
        #1 popCheck({7'b0, y});
        applyComb("track_lo", 8'hA2, 3'd3);
        #1 popCheck({7'b0, y});
        applyComb("track_hi2", 8'hAA, 3'd3);
        #1 popCheck({7'b0, y});

        for (int k = 0; k < 8; k++) begin
            for (int s = 0; s < 8; s++) begin
                applyComb($sformatf("onehot_k%0d_s%0d", k, s), 8'(1 << k), 3'(s));
                #1 popCheck({7'b0, y});
            end
        end

        sb.push_back('{"held_reset_yq", 8'h0});
        sb.push_back('{"held_reset_selq", 8'h0});
        checkRegs();

        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("first_cap", 8'hC3, 3'd7, 1'b1);
        #1 popCheck({7'b0, y});
        @(posedge clk);
        #1 checkRegs();

        @(negedge clk);
        applyStimulus("sel2", 8'hC3, 3'd2, 1'b1);
        #1 popCheck({7'b0, y});
        @(posedge clk);
        #1 checkRegs();

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            applyStimulus($sformatf("hold%0d", c), 8'(8'h5A ^ (c * 8'h33)), 3'(c + 3), 1'b0);
            #1 popCheck({7'b0, y});
            @(posedge clk);
            #1 checkRegs();
        end

        @(negedge clk);
        applyStimulus("reenable", 8'hC3, 3'd0, 1'b1);
        #1 popCheck({7'b0, y});
        @(posedge clk);
        #1 checkRegs();

        #2;
        rst_n  = 1'b0;
        capY   = 8'h0;
        capSel = 8'h0;
        #1;
        sb.push_back('{"async_y", model(8'hC3, 3'd0)});
        popCheck({7'b0, y});
        sb.push_back('{"async_yq", 8'h0});
        sb.push_back('{"async_selq", 8'h0});
        checkRegs();

        @(negedge clk);
        applyStimulus("in_reset", 8'hFF, 3'd5, 1'b1);
        capY   = 8'h0;
        capSel = 8'h0;
        sb.delete(sb.size() - 1);
        sb.delete(sb.size() - 1);
        sb.push_back('{"in_reset_yq", 8'h0});
        sb.push_back('{"in_reset_selq", 8'h0});
        #1 popCheck({7'b0, y});
        @(posedge clk);
        #1 checkRegs();

        checkOutput("sb_leftover", 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
